calc_accum_ctrl: RTL

Accumulator/sequencer stage directly upstream of the calculator's undo stack. It edge-detects the enter and undo buttons and applies the selected opcode to an accumulator. On every enter it pushes the pre-operation accumulator and the opcode into the stack. On undo it pops the stack and restores the accumulator. It drives the stack's push/pop and flag-clear handshake.

---
 rtl/calc_pkg.sv | 36 +++
 rtl/calc_alu.sv | 46 ++++
 rtl/calc_accum_ctrl.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/calc_pkg.sv
// calc_pkg: shared opcode/state enums and default widths for the calculator
// accumulator slice. Build option: CALC_UNDO_EN adds the POP_* states.
package calc_pkg;

  localparam int RESULT_W = 6;
  localparam int OPCODE_W = 3;
  localparam int DEPTH    = 6;

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_AND  = 3'd2,
    OP_OR   = 3'd3,
    OP_XOR  = 3'd4,
    OP_SHL  = 3'd5,
    OP_LOAD = 3'd6,
    OP_CLR  = 3'd7
  } opcode_e;

`ifdef CALC_UNDO_EN
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PUSH_REQ = 3'd1,
    ST_PUSH_CLR = 3'd2,
    ST_POP_REQ  = 3'd3,
    ST_POP_CLR  = 3'd4
  } state_e;
`else
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PUSH_REQ = 3'd1,
    ST_PUSH_CLR = 3'd2
  } state_e;
`endif

endpackage

// File: rtl/calc_alu.sv
// calc_alu: combinational opcode datapath, modulo 2^RESULT_W, with
// carry/borrow/shift-out reported on ovf.
module calc_alu #(
  parameter int RESULT_W = calc_pkg::RESULT_W,
  parameter int OPCODE_W = calc_pkg::OPCODE_W
) (
  input  logic [RESULT_W-1:0] i_a,
  input  logic [RESULT_W-1:0] i_b,
  input  logic [OPCODE_W-1:0] i_opcode,
  output logic [RESULT_W-1:0] o_y,
  output logic                o_ovf
);
  import calc_pkg::*;

  logic [RESULT_W:0] w_sum;
  logic [RESULT_W:0] w_diff;

  // Extended add/subtract so the top bit carries the carry-out or borrow
  always_comb begin
    w_sum  = {1'b0, i_a} + {1'b0, i_b};
    w_diff = {1'b0, i_a} - {1'b0, i_b};
    o_y    = '0;
    o_ovf  = 1'b0;
    case (opcode_e'(i_opcode))
      OP_ADD: begin
        o_y   = w_sum[RESULT_W-1:0];
        o_ovf = w_sum[RESULT_W];
      end
      OP_SUB: begin
        o_y   = w_diff[RESULT_W-1:0];
        o_ovf = w_diff[RESULT_W];
      end
      OP_AND:  o_y = i_a & i_b;
      OP_OR:   o_y = i_a | i_b;
      OP_XOR:  o_y = i_a ^ i_b;
      OP_SHL: begin
        o_y   = {i_a[RESULT_W-2:0], 1'b0};
        o_ovf = i_a[RESULT_W-1];
      end
      OP_LOAD: o_y = i_b;
      OP_CLR:  o_y = '0;
      default: o_y = '0;
    endcase
  end

endmodule

// File: rtl/calc_accum_ctrl.sv
// calc_accum_ctrl: button edge detect, accumulator and push/pop handshake
// sequencer feeding the calculator undo stack.
// Build option: define CALC_UNDO_EN to include the undo (pop) path; without it
// the undo button is ignored and pop/read_flag_reset stay low.
module calc_accum_ctrl #(
  parameter int RESULT_W = calc_pkg::RESULT_W,
  parameter int OPCODE_W = calc_pkg::OPCODE_W
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                enter,
  input  logic                undo,
  input  logic [RESULT_W-1:0] operand_in,
  input  logic [OPCODE_W-1:0] opcode_in,
  output logic [RESULT_W-1:0] acc_out,
  output logic [OPCODE_W-1:0] last_op,
  output logic                ovf,
  output logic                busy,
  output logic                err,
  output logic                push,
  output logic                pop,
  output logic [RESULT_W-1:0] resultin,
  output logic [OPCODE_W-1:0] opcodeselin,
  output logic                flag_reset,
  output logic                read_flag_reset,
  input  logic                flag,
  input  logic                readflag,
  input  logic                stack_full,
  input  logic                stack_empty,
  input  logic [RESULT_W-1:0] resulttos,
  input  logic [OPCODE_W-1:0] opcodeseltos
);
  import calc_pkg::*;

  state_e              r_state;
  logic                r_enter_prev;
  logic                r_enter_edge;
  logic [RESULT_W-1:0] r_acc;
  logic [RESULT_W-1:0] r_operand;
  logic [RESULT_W-1:0] r_resultin;
  logic [OPCODE_W-1:0] r_opcode;
  logic [OPCODE_W-1:0] r_last_op;
  logic                r_ovf;
  logic                r_err;
  logic                r_push;
  logic                r_flag_reset;
  logic [RESULT_W-1:0] w_alu_y;
  logic                w_alu_ovf;
`ifdef CALC_UNDO_EN
  logic                r_undo_prev;
  logic                r_undo_edge;
  logic                r_pop;
  logic                r_read_flag_reset;
`else
  logic                w_unused_undo;
`endif

  calc_alu #(
    .RESULT_W (RESULT_W),
    .OPCODE_W (OPCODE_W)
  ) u_alu (
    .i_a      (r_acc),
    .i_b      (r_operand),
    .i_opcode (r_opcode),
    .o_y      (w_alu_y),
    .o_ovf    (w_alu_ovf)
  );

  // Button history and registered rising-edge pulses (one cycle each)
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_enter_prev <= 1'b0;
      r_enter_edge <= 1'b0;
`ifdef CALC_UNDO_EN
      r_undo_prev  <= 1'b0;
      r_undo_edge  <= 1'b0;
`endif
    end else begin
      r_enter_prev <= enter;
      r_enter_edge <= enter & ~r_enter_prev;
`ifdef CALC_UNDO_EN
      r_undo_prev  <= undo;
      r_undo_edge  <= undo & ~r_undo_prev;
`endif
    end
  end

  // Sequencer: edges are only acted on in IDLE, so edges while busy are lost
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state           <= ST_IDLE;
      r_acc             <= '0;
      r_operand         <= '0;
      r_opcode          <= '0;
      r_resultin        <= '0;
      r_last_op         <= '0;
      r_ovf             <= 1'b0;
      r_err             <= 1'b0;
      r_push            <= 1'b0;
      r_flag_reset      <= 1'b0;
`ifdef CALC_UNDO_EN
      r_pop             <= 1'b0;
      r_read_flag_reset <= 1'b0;
`endif
    end else begin
      r_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          // Enter has priority over a coincident undo, which is dropped
          if (r_enter_edge) begin
            if (stack_full) begin
              r_err <= 1'b1;
            end else begin
              r_operand  <= operand_in;
              r_opcode   <= opcode_in;
              r_resultin <= r_acc;
              r_push     <= 1'b1;
              r_state    <= ST_PUSH_REQ;
            end
          end
`ifdef CALC_UNDO_EN
          else if (r_undo_edge) begin
            if (stack_empty) begin
              r_err <= 1'b1;
            end else begin
              r_pop   <= 1'b1;
              r_state <= ST_POP_REQ;
            end
          end
`endif
        end
        ST_PUSH_REQ: begin
          // Commit the ALU result only once the stack holds the old value
          if (flag) begin
            r_acc        <= w_alu_y;
            r_ovf        <= w_alu_ovf;
            r_last_op    <= r_opcode;
            r_push       <= 1'b0;
            r_flag_reset <= 1'b1;
            r_state      <= ST_PUSH_CLR;
          end
        end
        ST_PUSH_CLR: begin
          if (!flag) begin
            r_flag_reset <= 1'b0;
            r_state      <= ST_IDLE;
          end
        end
`ifdef CALC_UNDO_EN
        ST_POP_REQ: begin
          if (readflag) begin
            r_acc             <= resulttos;
            r_last_op         <= opcodeseltos;
            r_ovf             <= 1'b0;
            r_pop             <= 1'b0;
            r_read_flag_reset <= 1'b1;
            r_state           <= ST_POP_CLR;
          end
        end
        ST_POP_CLR: begin
          if (!readflag) begin
            r_read_flag_reset <= 1'b0;
            r_state           <= ST_IDLE;
          end
        end
`endif
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign acc_out     = r_acc;
  assign last_op     = r_last_op;
  assign ovf         = r_ovf;
  assign busy        = (r_state != ST_IDLE);
  assign err         = r_err;
  assign push        = r_push;
  assign resultin    = r_resultin;
  assign opcodeselin = r_opcode;
  assign flag_reset  = r_flag_reset;
`ifdef CALC_UNDO_EN
  assign pop             = r_pop;
  assign read_flag_reset = r_read_flag_reset;
`else
  assign pop             = 1'b0;
  assign read_flag_reset = 1'b0;
  assign w_unused_undo   = ^{undo, readflag, stack_empty, resulttos, opcodeseltos};
`endif

endmodule
